// File: rtl/stp_pkg.sv
// Shared constants, entry layout and FSM encoding for the STP state manager.
package stp_pkg;

  // Default configuration of the state manager.
  localparam int STP_DATA_WIDTH   = 18;
  localparam int STP_WEIGHT_WIDTH = 16;
  localparam int STP_N_SYN        = 64;
  localparam int STP_TIME_WIDTH   = 16;
  localparam int STP_U_BASE       = 64;
  localparam int STP_R_TARGET     = 256;
  localparam int STP_TAU_U_SHIFT  = 3;
  localparam int STP_TAU_R_SHIFT  = 3;
  localparam int STP_MAX_STEPS    = 16;

  // One RAM entry. The top module packs entries in this field order
  // ({u, r, last_t}, u in the MSBs) for any parameterisation.
  typedef struct packed {
    logic signed [STP_DATA_WIDTH-1:0] u;
    logic signed [STP_DATA_WIDTH-1:0] r;
    logic [STP_TIME_WIDTH-1:0]        last_t;
  } stp_state_t;

  // FSM encoding, kept as plain constants so older tools can consume it.
  typedef logic [2:0] fsm_state_e;
  localparam fsm_state_e ST_INIT  = 3'd0;
  localparam fsm_state_e ST_IDLE  = 3'd1;
  localparam fsm_state_e ST_READ  = 3'd2;
  localparam fsm_state_e ST_DECAY = 3'd3;
  localparam fsm_state_e ST_EVAL  = 3'd4;
  localparam fsm_state_e ST_WRITE = 3'd5;

endpackage

// File: rtl/stp_state_ram.sv
// Single-port synapse state RAM with synchronous read (read-before-write).
module stp_state_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 52,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write when enabled; the addressed word is always read out one cycle later.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stp_state_manager.sv
// Sequential wrapper around the combinational STP update stage: fetches the
// per-synapse state, relaxes it toward baseline for the elapsed timesteps,
// hands it to STP, and writes the STP result back.
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE, so at most one request
// is in flight. resp_valid is a one-cycle pulse; resp_* carry the written-back
// entry and are meaningful only while resp_valid is 1.
module stp_state_manager
  import stp_pkg::*;
#(
  parameter int DATA_WIDTH   = STP_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = STP_WEIGHT_WIDTH,
  parameter int N_SYN        = STP_N_SYN,
  parameter int TIME_WIDTH   = STP_TIME_WIDTH,
  parameter int U_BASE       = STP_U_BASE,
  parameter int R_TARGET     = STP_R_TARGET,
  parameter int TAU_U_SHIFT  = STP_TAU_U_SHIFT,
  parameter int TAU_R_SHIFT  = STP_TAU_R_SHIFT,
  parameter int MAX_STEPS    = STP_MAX_STEPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(N_SYN)-1:0] req_syn_id,
  input  logic                     req_spike,
  input  logic [WEIGHT_WIDTH-1:0]  req_weight,
  output logic                     stp_spike,
  output logic [DATA_WIDTH-1:0]    stp_u_decayed,
  output logic [DATA_WIDTH-1:0]    stp_R_decayed,
  output logic [WEIGHT_WIDTH-1:0]  stp_weight,
  input  logic [DATA_WIDTH-1:0]    stp_u_in,
  input  logic [DATA_WIDTH-1:0]    stp_R_in,
  input  logic [WEIGHT_WIDTH-1:0]  stp_efficacy_in,
  output logic                     resp_valid,
  output logic [$clog2(N_SYN)-1:0] resp_syn_id,
  output logic [DATA_WIDTH-1:0]    resp_u,
  output logic [DATA_WIDTH-1:0]    resp_R,
  output logic [WEIGHT_WIDTH-1:0]  resp_efficacy
);

  localparam int ID_W    = $clog2(N_SYN);
  localparam int ENTRY_W = 2 * DATA_WIDTH + TIME_WIDTH;

  localparam logic signed [DATA_WIDTH-1:0] U_BASE_V   = DATA_WIDTH'(U_BASE);
  localparam logic signed [DATA_WIDTH-1:0] R_TARGET_V = DATA_WIDTH'(R_TARGET);
  localparam logic [ID_W-1:0]              LAST_ID    = ID_W'(N_SYN - 1);
  localparam logic [TIME_WIDTH-1:0]        MAX_STEPS_V = TIME_WIDTH'(MAX_STEPS);

  fsm_state_e                    state_q;
  logic [TIME_WIDTH-1:0]         t_now;
  logic [TIME_WIDTH-1:0]         t_cap;
  logic [TIME_WIDTH-1:0]         steps_q;
  logic [ID_W-1:0]               init_idx;
  logic [ID_W-1:0]               id_q;
  logic                          spike_q;
  logic [WEIGHT_WIDTH-1:0]       weight_q;
  logic signed [DATA_WIDTH-1:0]  u_q;
  logic signed [DATA_WIDTH-1:0]  r_q;
  logic [DATA_WIDTH-1:0]         u_cap;
  logic [DATA_WIDTH-1:0]         r_cap;
  logic [WEIGHT_WIDTH-1:0]       eff_cap;
  logic                          resp_valid_q;

  logic                          ram_we;
  logic [ID_W-1:0]               ram_addr;
  logic [ENTRY_W-1:0]            ram_wdata;
  logic [ENTRY_W-1:0]            ram_rdata;

  logic signed [DATA_WIDTH-1:0]  rd_u;
  logic signed [DATA_WIDTH-1:0]  rd_r;
  logic [TIME_WIDTH-1:0]         rd_t;
  logic [TIME_WIDTH-1:0]         elapsed;
  logic signed [DATA_WIDTH-1:0]  u_diff;
  logic signed [DATA_WIDTH-1:0]  r_diff;
  logic signed [DATA_WIDTH-1:0]  u_step;
  logic signed [DATA_WIDTH-1:0]  r_step;

  stp_state_ram #(
    .DEPTH (N_SYN),
    .WIDTH (ENTRY_W),
    .ADDR_W(ID_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Entry fields; layout matches stp_state_t ({u, r, last_t}).
  assign rd_u = ram_rdata[ENTRY_W-1 -: DATA_WIDTH];
  assign rd_r = ram_rdata[TIME_WIDTH +: DATA_WIDTH];
  assign rd_t = ram_rdata[TIME_WIDTH-1:0];

  // Modular distance from the stored timestamp; aliasing after a full wrap is accepted.
  assign elapsed = t_cap - rd_t;

  // One relaxation step toward baseline; the arithmetic shift floors negative gaps.
  assign u_diff = U_BASE_V - u_q;
  assign r_diff = R_TARGET_V - r_q;
  assign u_step = u_q + (u_diff >>> TAU_U_SHIFT);
  assign r_step = r_q + (r_diff >>> TAU_R_SHIFT);

  // RAM port steering: init sweep, writeback, otherwise pre-read the incoming id.
  // Writes are suppressed during reset so an interrupted request leaves no trace.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = req_syn_id;
    ram_wdata = {u_cap, r_cap, t_cap};
    case (state_q)
      ST_INIT: begin
        ram_we    = rst_n;
        ram_addr  = init_idx;
        ram_wdata = {U_BASE_V, R_TARGET_V, {TIME_WIDTH{1'b0}}};
      end
      ST_WRITE: begin
        ram_we   = rst_n;
        ram_addr = id_q;
      end
      default: ;
    endcase
  end

  // Main FSM, timestep counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      t_now        <= '0;
      t_cap        <= '0;
      steps_q      <= '0;
      init_idx     <= '0;
      id_q         <= '0;
      spike_q      <= 1'b0;
      weight_q     <= '0;
      u_q          <= '0;
      r_q          <= '0;
      u_cap        <= '0;
      r_cap        <= '0;
      eff_cap      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      if (tick) begin
        t_now <= t_now + TIME_WIDTH'(1);
      end
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_idx <= init_idx + ID_W'(1);
          if (init_idx == LAST_ID) begin
            init_idx <= '0;
            state_q  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            id_q     <= req_syn_id;
            spike_q  <= req_spike;
            weight_q <= req_weight;
            t_cap    <= t_now;
            state_q  <= ST_READ;
          end
        end
        ST_READ: begin
          u_q     <= rd_u;
          r_q     <= rd_r;
          steps_q <= elapsed;
          if (elapsed == '0) begin
            state_q <= ST_EVAL;
          end else if (elapsed >= MAX_STEPS_V) begin
            u_q     <= U_BASE_V;
            r_q     <= R_TARGET_V;
            state_q <= ST_EVAL;
          end else begin
            state_q <= ST_DECAY;
          end
        end
        ST_DECAY: begin
          u_q     <= u_step;
          r_q     <= r_step;
          steps_q <= steps_q - TIME_WIDTH'(1);
          if (steps_q == TIME_WIDTH'(1)) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          u_cap   <= stp_u_in;
          r_cap   <= stp_R_in;
          eff_cap <= stp_efficacy_in;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign stp_u_decayed = u_q;
  assign stp_R_decayed = r_q;
  assign stp_spike     = (state_q == ST_EVAL) && spike_q;
  assign stp_weight    = (state_q == ST_EVAL) ? weight_q : '0;
  assign resp_valid    = resp_valid_q;
  assign resp_syn_id   = id_q;
  assign resp_u        = u_cap;
  assign resp_R        = r_cap;
  assign resp_efficacy = eff_cap;

endmodule

// File: tb/tb_stp_state_manager.sv
// Directed bench for stp_state_manager: table of request vectors plus
// hand-written sequences for backpressure, mid-flight reset and timestamp wrap.
module tb_stp_state_manager;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        tick;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_syn_id;
  logic        req_spike;
  logic [15:0] req_weight;
  logic        stp_spike;
  logic [17:0] stp_u_decayed;
  logic [17:0] stp_R_decayed;
  logic [15:0] stp_weight;
  logic [17:0] stp_u_in;
  logic [17:0] stp_R_in;
  logic [15:0] stp_efficacy_in;
  logic        resp_valid;
  logic [5:0]  resp_syn_id;
  logic [17:0] resp_u;
  logic [17:0] resp_R;
  logic [15:0] resp_efficacy;

  stp_state_manager dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_syn_id     (req_syn_id),
    .req_spike      (req_spike),
    .req_weight     (req_weight),
    .stp_spike      (stp_spike),
    .stp_u_decayed  (stp_u_decayed),
    .stp_R_decayed  (stp_R_decayed),
    .stp_weight     (stp_weight),
    .stp_u_in       (stp_u_in),
    .stp_R_in       (stp_R_in),
    .stp_efficacy_in(stp_efficacy_in),
    .resp_valid     (resp_valid),
    .resp_syn_id    (resp_syn_id),
    .resp_u         (resp_u),
    .resp_R         (resp_R),
    .resp_efficacy  (resp_efficacy)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int ticks;    // ticks applied before the request
    int id;
    int spike;
    int weight;
    int ret_u;    // STP model return values
    int ret_r;
    int ret_eff;
    int exp_u;    // expected decayed values seen by STP
    int exp_r;
    int exp_lat;  // cycles from accept edge to resp_valid
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_ticks(input int n);
    if (n > 0) begin
      @(negedge clk);
      tick = 1'b1;
      repeat (n) @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  // Called at the negedge where rst_n rises; counts not-ready cycles of the init sweep.
  task automatic check_init(input string name);
    int cyc = 0;
    int resp_seen = 0;
    while (req_ready !== 1'b1 && cyc < 200) begin
      if (resp_valid) resp_seen++;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("%s init_cycles", name), cyc, 64);
    check($sformatf("%s init_resp", name), resp_seen, 0);
  endtask

  // Called just after the accepting edge. Samples every negedge; the EVAL cycle
  // is two samples before the response pulse.
  task automatic wait_resp(input string name, input int id, input int spike,
                           input int weight, input int ret_u, input int ret_r,
                           input int ret_eff, input int exp_u, input int exp_r,
                           input int exp_lat, input int tick_at);
    int hu[64];
    int hr[64];
    int hw[64];
    int hs[64];
    int i;
    int e;
    bit seen = 1'b0;
    int busy_ready = 0;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      tick = (i == tick_at);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      hu[i] = $signed(stp_u_decayed);
      hr[i] = $signed(stp_R_decayed);
      hw[i] = $signed(stp_weight);
      hs[i] = int'(stp_spike);
      if (req_ready) busy_ready++;
    end
    tick = 1'b0;
    if (!seen) begin
      check($sformatf("%s resp_timeout", name), 0, 1);
    end else begin
      e = (i >= 2) ? i - 2 : 0;
      check($sformatf("%s latency", name), i, exp_lat);
      check($sformatf("%s eval_u", name), hu[e], exp_u);
      check($sformatf("%s eval_R", name), hr[e], exp_r);
      check($sformatf("%s eval_spike", name), hs[e], spike);
      check($sformatf("%s eval_weight", name), hw[e], weight);
      check($sformatf("%s busy_ready", name), busy_ready, 0);
      check($sformatf("%s resp_id", name), int'(resp_syn_id), id);
      check($sformatf("%s resp_u", name), $signed(resp_u), ret_u);
      check($sformatf("%s resp_R", name), $signed(resp_R), ret_r);
      check($sformatf("%s resp_eff", name), $signed(resp_efficacy), ret_eff);
      check($sformatf("%s gate_spike", name), int'(stp_spike), 0);
      check($sformatf("%s gate_weight", name), $signed(stp_weight), 0);
    end
  endtask

  // Driver: wait for ready, present one request for one accepting edge, then track it.
  task automatic do_req(input vec_t v, input string name);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check($sformatf("%s ready_timeout", name), 0, 1);
    req_valid       = 1'b1;
    req_syn_id      = 6'(v.id);
    req_spike       = (v.spike != 0);
    req_weight      = 16'(v.weight);
    stp_u_in        = 18'(v.ret_u);
    stp_R_in        = 18'(v.ret_r);
    stp_efficacy_in = 16'(v.ret_eff);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(name, v.id, v.spike, v.weight, v.ret_u, v.ret_r, v.ret_eff,
              v.exp_u, v.exp_r, v.exp_lat, -1);
  endtask

  initial begin
    vec_t v;
    //           ticks id sp weight  ret_u ret_r eff   exp_u exp_r lat
    vecs[0]  = '{0,    5, 0,  123,   64,   256,  0,    64,   256,  3};
    vecs[1]  = '{0,    2, 1,  1000,  100,  128,  500,  64,   256,  3};
    vecs[2]  = '{2,    2, 0,  -5,    91,   158,  0,    91,   158,  5};
    vecs[3]  = '{20,   2, 0,  0,     64,   256,  0,    64,   256,  3};
    vecs[4]  = '{0,    7, 1,  -1200, 200,  40,   -300, 64,   256,  3};
    vecs[5]  = '{1,    7, 0,  42,    183,  67,   0,    183,  67,   4};
    vecs[6]  = '{16,   7, 0,  0,     64,   256,  0,    64,   256,  3};
    vecs[7]  = '{15,   7, 0,  0,     64,   256,  0,    64,   256,  18};
    vecs[8]  = '{0,   63, 1,  32767, 0,    0,    7,    64,   256,  3};
    vecs[9]  = '{3,   63, 0,  0,     21,   84,   0,    21,   84,   6};
    vecs[10] = '{0,    9, 1,  5,     100,  128,  9,    64,   256,  3};

    rst_n = 1'b0;
    tick = 1'b0;
    req_valid = 1'b0;
    req_syn_id = '0;
    req_spike = 1'b0;
    req_weight = '0;
    stp_u_in = '0;
    stp_R_in = '0;
    stp_efficacy_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", int'(req_ready), 0);
    check("rst resp_valid", int'(resp_valid), 0);
    check("rst stp_spike", int'(stp_spike), 0);
    check("rst stp_weight", int'(stp_weight), 0);
    check("rst stp_u", int'(stp_u_decayed), 0);
    check("rst stp_R", int'(stp_R_decayed), 0);
    check("rst resp_u", int'(resp_u), 0);
    rst_n = 1'b1;
    check_init("reset");

    // Table-driven vectors
    for (int k = 0; k < 11; k++) begin
      apply_ticks(vecs[k].ticks);
      do_req(vecs[k], $sformatf("vec%0d", k));
    end

    // Backpressure: req_valid held through a 2-step decay with a tick mid-flight;
    // the held request is accepted once back in IDLE and sees elapsed = 1.
    apply_ticks(2);
    @(negedge clk);
    req_valid       = 1'b1;
    req_syn_id      = 6'd9;
    req_spike       = 1'b0;
    req_weight      = 16'd77;
    stp_u_in        = 18'd91;
    stp_R_in        = 18'd158;
    stp_efficacy_in = 16'd0;
    @(posedge clk);
    wait_resp("held1", 9, 0, 77, 91, 158, 0, 91, 158, 5, 2);
    stp_u_in        = 18'd87;
    stp_R_in        = 18'd170;
    stp_efficacy_in = 16'd11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp("held2", 9, 0, 77, 87, 170, 11, 87, 170, 4, -1);

    // Reset during DECAY: no response, init sweep reruns, state back at baseline.
    apply_ticks(3);
    @(negedge clk);
    req_valid  = 1'b1;
    req_syn_id = 6'd9;
    req_weight = 16'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid resp_valid", int'(resp_valid), 0);
    rst_n = 1'b1;
    check_init("rst_mid");
    v = '{0, 2, 0, 0, 64, 256, 0, 64, 256, 3};
    do_req(v, "rst_mid syn2");
    v = '{0, 9, 0, 0, 64, 256, 0, 64, 256, 3};
    do_req(v, "rst_mid syn9");

    // Timestamp wrap: last_t = 0xFFFF, t_now = 0x0001 -> two decay steps.
    apply_ticks(65535);
    v = '{0, 4, 1, 300, 100, 128, 3, 64, 256, 3};
    do_req(v, "wrap spike");
    apply_ticks(2);
    v = '{0, 4, 0, 0, 91, 158, 0, 91, 158, 5};
    do_req(v, "wrap refresh");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
